// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV32I instruction fields into machine
// words and streams them into instruction memory, one word per cycle.
// Each bundle is range/alignment checked; the first failing bundle stops the
// session with a sticky error code until the next start or reset.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_OPCODE   = 3'd1;
    localparam logic [2:0] E_RANGE    = 3'd2;
    localparam logic [2:0] E_ALIGN    = 3'd3;
    localparam logic [2:0] E_OVERFLOW = 3'd4;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q,      state_d;
    logic              mem_we_q,     mem_we_d;
    logic [31:0]       mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic              err_q,        err_d;
    logic [2:0]        err_code_q,   err_code_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic              op_known;
    logic              imm_bad;
    logic              misaligned;
    logic [31:0]       enc_word;
    logic [2:0]        err_sel;
    logic [ADDR_W-1:0] word_idx;

    // Encode the incoming bundle and flag range/alignment violations
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        op_known   = 1'b1;
        imm_bad    = 1'b0;
        misaligned = 1'b0;
        enc_word   = '0;
        case (in_opcode)
            OP_R: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_LOAD, OP_JALR, OP_IMM: begin
                if (in_opcode == OP_IMM && (in_funct3 == 3'b001 || in_funct3 == 3'b101)) begin
                    // Shift-immediate: shamt is unsigned 5-bit, funct7 carries the arith flag
                    enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    imm_bad  = |in_imm[31:5];
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    imm_bad  = in_imm[31:12] != {20{in_imm[11]}};
                end
            end
            OP_STORE: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                imm_bad  = in_imm[31:12] != {20{in_imm[11]}};
            end
            OP_BRANCH: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                imm_bad    = in_imm[31:13] != {19{in_imm[12]}};
                misaligned = in_imm[0];
            end
            OP_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                imm_bad    = in_imm[31:21] != {11{in_imm[20]}};
                misaligned = in_imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {in_imm[31:12], in_rd, in_opcode};
                imm_bad  = |in_imm[11:0];
            end
            default: op_known = 1'b0;
        endcase
    end

    // Resolve the error cause with priority overflow > opcode > range > alignment
    always_comb begin
        if (word_count_q == DEPTH_W)  err_sel = E_OVERFLOW;
        else if (!op_known)           err_sel = E_OPCODE;
        else if (imm_bad)             err_sel = E_RANGE;
        else if (misaligned)          err_sel = E_ALIGN;
        else                          err_sel = E_NONE;
    end

    assign word_idx = word_count_q[ADDR_W-1:0];

    // Session state machine and write-port next state
    always_comb begin
        state_d      = state_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        word_count_d = word_count_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (err_sel != E_NONE) begin
                        err_d      = 1'b1;
                        err_code_d = err_sel;
                        state_d    = S_ERR;
                    end else begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = BASE_ADDR + (32'(word_idx) << 2);
                        mem_wdata_d  = enc_word;
                        word_count_d = word_count_q + 1'b1;
                        if (in_last) state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        // start is honoured from every state except LOAD
        if (state_q != S_LOAD && start) begin
            state_d      = S_LOAD;
            word_count_d = '0;
            err_d        = 1'b0;
            err_code_d   = E_NONE;
        end
    end

    // Register all state; synchronous reset clears everything and drops pending writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_q        <= 1'b0;
            err_code_q   <= E_NONE;
            word_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: directed scenarios plus randomized
// bundles checked against an arithmetic reference encoder.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid, in_last;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;

    // default instance
    logic        a_in_ready, a_mem_we, a_busy, a_done, a_err;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [2:0]  a_err_code;
    logic [ADDR_W:0] a_word_count;
    // small-depth instance with a base address near the top of the space
    logic        b_in_ready, b_mem_we, b_busy, b_done, b_err;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [2:0]  b_err_code;
    logic [ADDR_W:0] b_word_count;

    localparam logic [31:0] B_BASE = 32'hFFFF_FFF8;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(1024), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .busy(a_busy),
        .done(a_done), .err(a_err), .err_code(a_err_code), .word_count(a_word_count));

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE_ADDR(B_BASE)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .busy(b_busy),
        .done(b_done), .err(b_err), .err_code(b_err_code), .word_count(b_word_count));

    int errors = 0;
    int checks = 0;

    // Reference encoder: ranges checked with signed arithmetic on the whole immediate
    function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] imm,
                                       output logic [31:0] w, output int code);
        int s;
        s = $signed(imm);
        w = '0;
        code = 0;
        case (op)
            7'b0110011: w = {f7, rs2, rs1, f3, rd, op};
            7'b0010011, 7'b0000011, 7'b1100111: begin
                if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    if (imm > 32'd31) code = 2;
                    w = {f7, imm[4:0], rs1, f3, rd, op};
                end else begin
                    if (s < -2048 || s > 2047) code = 2;
                    w = {imm[11:0], rs1, f3, rd, op};
                end
            end
            7'b0100011: begin
                if (s < -2048 || s > 2047) code = 2;
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            7'b1100011: begin
                if (s < -4096 || s > 4095) code = 2;
                else if (imm % 2 != 0) code = 3;
                w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            7'b1101111: begin
                if (s < -1048576 || s > 1048575) code = 2;
                else if (imm % 2 != 0) code = 3;
                w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            7'b0110111, 7'b0010111: begin
                if (imm % 4096 != 0) code = 2;
                w = {imm[31:12], rd, op};
            end
            default: code = 1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic set_bundle(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic last);
        in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    endtask

    task automatic do_start();
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Random legal bundle of any format
    task automatic gen_legal(output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7,
                             output logic [31:0] imm);
        logic [6:0] ops [9] = '{7'b0110011, 7'b0000011, 7'b1100111, 7'b0010011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
        op  = ops[$urandom_range(0, 8)];
        f3  = 3'($urandom_range(0, 7));
        f7  = 7'($urandom_range(0, 127));
        case (op)
            7'b0110011: imm = $urandom;
            7'b0010011: begin
                if (f3 == 3'd1 || f3 == 3'd5) imm = 32'($urandom_range(0, 31));
                else imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            end
            7'b0000011, 7'b1100111, 7'b0100011: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            7'b1100011: imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            7'b1101111: imm = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
            default:    imm = $urandom & 32'hFFFF_F000;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_last = 1'b1;
        in_opcode = 7'b0010011; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd5;
        step(); step();
        checks++; if ({a_in_ready, a_mem_we, a_busy, a_done, a_err} !== 5'b0) begin errors++;
            $display("FAIL reset_flags: got %b expected 00000", {a_in_ready, a_mem_we, a_busy, a_done, a_err}); end
        checks++; if (a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0) begin errors++;
            $display("FAIL reset_mem: got addr=%h data=%h expected 0/0", a_mem_addr, a_mem_wdata); end
        checks++; if (a_err_code !== 3'd0 || a_word_count !== '0) begin errors++;
            $display("FAIL reset_code_count: got code=%0d count=%0d expected 0/0", a_err_code, a_word_count); end
        rst_n = 1'b1;
        idle_inputs();
        step();
        checks++; if (a_in_ready !== 1'b0) begin errors++;
            $display("FAIL reset_idle_ready: got %b expected 0", a_in_ready); end
    endtask

    task automatic test_single_addi();
        do_start();
        checks++; if (a_in_ready !== 1'b1 || a_busy !== 1'b1 || a_word_count !== '0) begin errors++;
            $display("FAIL start_load: got ready=%b busy=%b count=%0d expected 1/1/0", a_in_ready, a_busy, a_word_count); end
        set_bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        step();
        idle_inputs();
        checks++; if (a_mem_we !== 1'b1 || a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0050_0093) begin errors++;
            $display("FAIL addi_write: got we=%b addr=%h data=%h expected 1/00000000/00500093", a_mem_we, a_mem_addr, a_mem_wdata); end
        checks++; if (a_done !== 1'b1 || a_word_count !== 11'd1 || a_in_ready !== 1'b0) begin errors++;
            $display("FAIL addi_done: got done=%b count=%0d ready=%b expected 1/1/0", a_done, a_word_count, a_in_ready); end
        step();
        checks++; if (a_mem_we !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0 || a_mem_wdata !== 32'h0050_0093) begin errors++;
            $display("FAIL addi_after: got we=%b done=%b busy=%b data=%h expected 0/0/0/00500093", a_mem_we, a_done, a_busy, a_mem_wdata); end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ops  [4] = '{7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111};
        logic [4:0]  rds  [4] = '{5'd0, 5'd0, 5'd1, 5'd5};
        logic [4:0]  rs1s [4] = '{5'd1, 5'd1, 5'd0, 5'd0};
        logic [4:0]  rs2s [4] = '{5'd2, 5'd2, 5'd0, 5'd0};
        logic [2:0]  f3s  [4] = '{3'd2, 3'd0, 3'd0, 3'd0};
        logic [31:0] imms [4] = '{32'd8, 32'hFFFF_FFFC, 32'd2048, 32'h1234_5000};
        logic [31:0] exp  [4] = '{32'h0020_A423, 32'hFE20_8EE3, 32'h0010_00EF, 32'h1234_52B7};
        do_start();
        for (int i = 0; i < 4; i++) begin
            set_bundle(ops[i], rds[i], rs1s[i], rs2s[i], f3s[i], 7'd0, imms[i], i == 3);
            step();
            checks++; if (a_mem_we !== 1'b1 || a_mem_addr !== 32'(4 * i) || a_mem_wdata !== exp[i] || a_done !== (i == 3)) begin errors++;
                $display("FAIL b2b_word%0d: got we=%b addr=%h data=%h done=%b expected 1/%h/%h/%b",
                         i, a_mem_we, a_mem_addr, a_mem_wdata, a_done, 32'(4 * i), exp[i], i == 3); end
        end
        idle_inputs();
        step();
        checks++; if (a_in_ready !== 1'b0 || a_mem_we !== 1'b0 || a_word_count !== 11'd4) begin errors++;
            $display("FAIL b2b_end: got ready=%b we=%b count=%0d expected 0/0/4", a_in_ready, a_mem_we, a_word_count); end
    endtask

    task automatic test_imm_range_err();
        do_start();
        set_bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        step();
        checks++; if (a_mem_we !== 1'b1) begin errors++;
            $display("FAIL range_first_write: got we=%b expected 1", a_mem_we); end
        set_bundle(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        step();
        checks++; if (a_mem_we !== 1'b0 || a_err !== 1'b1 || a_err_code !== 3'd2 || a_in_ready !== 1'b0 || a_word_count !== 11'd1) begin errors++;
            $display("FAIL range_err: got we=%b err=%b code=%0d ready=%b count=%0d expected 0/1/2/0/1",
                     a_mem_we, a_err, a_err_code, a_in_ready, a_word_count); end
        set_bundle(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (a_mem_we !== 1'b0 || a_err !== 1'b1 || a_err_code !== 3'd2) begin errors++;
                $display("FAIL range_sticky%0d: got we=%b err=%b code=%0d expected 0/1/2", i, a_mem_we, a_err, a_err_code); end
        end
        do_start();
        checks++; if (a_err !== 1'b0 || a_err_code !== 3'd0 || a_word_count !== '0 || a_in_ready !== 1'b1) begin errors++;
            $display("FAIL range_restart: got err=%b code=%0d count=%0d ready=%b expected 0/0/0/1", a_err, a_err_code, a_word_count, a_in_ready); end
        set_bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1);
        step();
        idle_inputs();
        checks++; if (a_mem_we !== 1'b1 || a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0070_0093) begin errors++;
            $display("FAIL range_restart_write: got we=%b addr=%h data=%h expected 1/00000000/00700093", a_mem_we, a_mem_addr, a_mem_wdata); end
        step();
    endtask

    task automatic test_bad_fields();
        logic [6:0]  ops  [7] = '{7'b1100011, 7'b1111111, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010011, 7'b0100011};
        logic [2:0]  f3s  [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
        logic [31:0] imms [7] = '{32'd3, 32'd0, 32'h0000_2001, 32'd1, 32'h0000_0123, 32'd32, 32'hFFFF_F7FF};
        logic [2:0]  exp  [7] = '{3'd3, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2};
        for (int i = 0; i < 7; i++) begin
            do_start();
            set_bundle(ops[i], 5'd1, 5'd1, 5'd2, f3s[i], 7'd0, imms[i], 1'b1);
            step();
            idle_inputs();
            checks++; if (a_mem_we !== 1'b0 || a_err !== 1'b1 || a_err_code !== exp[i]) begin errors++;
                $display("FAIL bad_field%0d: got we=%b err=%b code=%0d expected 0/1/%0d", i, a_mem_we, a_err, a_err_code, exp[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w;
        int code;
        do_start();
        for (int i = 0; i < 4; i++) begin
            set_bundle(7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 1'b0);
            ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, code);
            step();
            checks++; if (b_mem_we !== 1'b1 || b_mem_addr !== B_BASE + 32'(4 * i) || b_mem_wdata !== w) begin errors++;
                $display("FAIL ovf_write%0d: got we=%b addr=%h data=%h expected 1/%h/%h",
                         i, b_mem_we, b_mem_addr, b_mem_wdata, B_BASE + 32'(4 * i), w); end
        end
        set_bundle(7'b1111111, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        step();
        idle_inputs();
        checks++; if (b_mem_we !== 1'b0 || b_err !== 1'b1 || b_err_code !== 3'd4 || b_word_count !== 11'd4) begin errors++;
            $display("FAIL ovf_err: got we=%b err=%b code=%0d count=%0d expected 0/1/4/4", b_mem_we, b_err, b_err_code, b_word_count); end
        step();
    endtask

    task automatic test_reset_mid();
        do_start();
        set_bundle(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        step();
        checks++; if (a_mem_we !== 1'b1) begin errors++;
            $display("FAIL rstmid_pre: got we=%b expected 1", a_mem_we); end
        rst_n = 1'b0;
        set_bundle(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b0);
        step();
        checks++; if ({a_in_ready, a_mem_we, a_busy, a_done, a_err} !== 5'b0 || a_mem_addr !== 32'h0 ||
                      a_mem_wdata !== 32'h0 || a_err_code !== 3'd0 || a_word_count !== '0) begin errors++;
            $display("FAIL rstmid_outputs: got flags=%b addr=%h data=%h code=%0d count=%0d expected all 0",
                     {a_in_ready, a_mem_we, a_busy, a_done, a_err}, a_mem_addr, a_mem_wdata, a_err_code, a_word_count); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (a_mem_we !== 1'b0 || a_in_ready !== 1'b0) begin errors++;
                $display("FAIL rstmid_ignore%0d: got we=%b ready=%b expected 0/0", i, a_mem_we, a_in_ready); end
        end
        idle_inputs();
    endtask

    task automatic test_random_stream();
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] imm, w;
        int code, n, sent;
        bit v;
        for (int sess = 0; sess < 4; sess++) begin
            do_start();
            n = $urandom_range(1, 24);
            sent = 0;
            while (sent < n) begin
                v = ($urandom_range(0, 3) != 0);
                if (v) begin
                    gen_legal(op, f3, f7, imm);
                    set_bundle(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                               5'($urandom_range(0, 31)), f3, f7, imm, sent == n - 1);
                    ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, code);
                end else begin
                    in_valid = 1'b0; in_last = 1'b0;
                end
                step();
                if (v) begin
                    checks++; if (code != 0 || a_mem_we !== 1'b1 || a_mem_addr !== 32'(4 * sent) || a_mem_wdata !== w ||
                                  a_done !== (sent == n - 1) || a_word_count !== 11'(sent + 1)) begin errors++;
                        $display("FAIL rand_word s%0d i%0d: got we=%b addr=%h data=%h done=%b count=%0d expected 1/%h/%h/%b/%0d (model code %0d)",
                                 sess, sent, a_mem_we, a_mem_addr, a_mem_wdata, a_done, a_word_count,
                                 32'(4 * sent), w, sent == n - 1, sent + 1, code); end
                    sent++;
                end else begin
                    checks++; if (a_mem_we !== 1'b0) begin errors++;
                        $display("FAIL rand_gap s%0d: got we=%b expected 0", sess, a_mem_we); end
                end
            end
            idle_inputs();
            step();
            checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errors++;
                $display("FAIL rand_end s%0d: got busy=%b done=%b expected 0/0", sess, a_busy, a_done); end
        end
    endtask

    task automatic test_random_errors();
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] imm, w;
        int code;
        for (int i = 0; i < 60; i++) begin
            do_start();
            gen_legal(op, f3, f7, imm);
            if ($urandom_range(0, 5) == 0) op = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
                2: imm = 32'($urandom_range(0, 63));
                default: ;
            endcase
            set_bundle(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), f3, f7, imm, 1'b1);
            ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, w, code);
            step();
            idle_inputs();
            if (code == 0) begin
                checks++; if (a_mem_we !== 1'b1 || a_mem_wdata !== w || a_done !== 1'b1 || a_err !== 1'b0) begin errors++;
                    $display("FAIL rerr_ok%0d: op=%b f3=%0d imm=%h got we=%b data=%h done=%b err=%b expected 1/%h/1/0",
                             i, op, f3, imm, a_mem_we, a_mem_wdata, a_done, a_err, w); end
            end else begin
                checks++; if (a_mem_we !== 1'b0 || a_err !== 1'b1 || a_err_code !== 3'(code)) begin errors++;
                    $display("FAIL rerr_bad%0d: op=%b f3=%0d imm=%h got we=%b err=%b code=%0d expected 0/1/%0d",
                             i, op, f3, imm, a_mem_we, a_err, a_err_code, code); end
            end
        end
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_addi();
        test_back_to_back();
        test_imm_range_err();
        test_bad_fields();
        test_overflow();
        test_reset_mid();
        test_random_stream();
        test_random_errors();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's instruction decoder. It accepts decoded instruction fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) over a valid/ready stream and packs them into RV32I words.
- Immediate packing covers R/I/S/B/J/U formats. Each immediate is checked for range and alignment before it is packed.
- Packed words are written sequentially into instruction memory through a write port. Used by the test/boot infrastructure to load programs without an external assembler.

Parameters:
- ADDR_W, 10, width of the word index; instruction memory holds 2^ADDR_W words.
- DEPTH, 1024, maximum words accepted per load session (DEPTH <= 2^ADDR_W).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begins a load session; clears counter and error.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block accepts the bundle this cycle.
- in_opcode  in  7  opcode field.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R-type and shift-immediate only).
- in_imm  in  32  sign-extended immediate, byte offset for B/J, full upper value for U.
- in_last  in  1  marks the final bundle of the session.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  32  byte address, BASE_ADDR + 4*index.
- mem_wdata  out  32  encoded instruction word.
- busy  out  1  high in LOAD state.
- done  out  1  one-cycle pulse, coincident with the final write.
- err  out  1  sticky error flag.
- err_code  out  3  error cause: 0 none, 1 bad opcode, 2 immediate out of range, 3 misaligned offset, 4 overflow.
- word_count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE. All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code, word_count. Any pending write is dropped. Reset wins over every other input.
- State machine: IDLE, LOAD, DONE, ERR.
  - IDLE/DONE/ERR + start -> LOAD next cycle; word_count=0, err=0, err_code=0.
  - LOAD: start is ignored.
  - DONE -> IDLE after one cycle.
- in_ready = (state==LOAD). A transfer occurs when in_valid && in_ready.
- Latency: a bundle accepted at edge N produces mem_we=1 with registered mem_addr/mem_wdata for exactly cycle N+1. word_count increments at the same edge. Throughput is one word per cycle with no memory backpressure.
- in_last accepted without error -> state DONE. done=1 during the cycle of that final write, which is also the DONE-state cycle.
- Encoding by opcode:
  - OP 0110011 (R): funct7|rs2|rs1|funct3|rd|op.
  - LOAD 0000011, JALR 1100111, OP_IMM 0010011 (I): imm[11:0]|rs1|funct3|rd|op.
  - OP_IMM with funct3 001 or 101 (shift): funct7|imm[4:0]|rs1|funct3|rd|op.
  - STORE 0100011 (S): imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - BRANCH 1100011 (B): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - JAL 1101111 (J): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - LUI 0110111, AUIPC 0010111 (U): imm[31:12]|rd|op.
- Checks, evaluated on the accepted bundle:
  - Opcode not in the list above -> code 1.
  - I/S: imm is not the sign extension of imm[11:0] -> code 2.
  - Shift: imm[31:5] != 0 -> code 2.
  - B: imm is not the sign extension of imm[12:0] -> code 2; imm[0]=1 -> code 3.
  - J: imm is not the sign extension of imm[20:0] -> code 2; imm[0]=1 -> code 3.
  - U: imm[11:0] != 0 -> code 2.
  - Bundle accepted while word_count == DEPTH -> code 4.
  - Priority when several fail: 4 > 1 > 2 > 3.
- On error:
  - No write for that bundle; mem_we stays 0.
  - err=1 and err_code latch at the next edge; state ERR, so in_ready=0 from the next cycle.
  - Writes already completed are kept.
  - err and err_code hold until start or reset.
- mem_addr and mem_wdata hold their last value when mem_we=0.
- Address arithmetic is 32-bit and wraps modulo 2^32. The word index is ADDR_W bits.

Test Plan:
- start, then bundle addi x1,x0,5 (op 0010011, rd=1, rs1=0, f3=0, imm=5) with in_last=1 -> next cycle mem_we=1, mem_addr=0x0, mem_wdata=0x00500093, done=1, word_count=1; IDLE afterwards.
- Back-to-back stream: sw x2,8(x1); beq x1,x2,-4; jal x1,2048; lui x5,0x12345000 (last) -> consecutive writes of 0x0020A423, 0x00208EE3 for beq... corrected: 0xFE208EE3, then 0x001000EF, 0x123452B7, at addresses 0x0, 0x4, 0x8, 0xC; done with the 4th write.
- addi with imm=2048 as second bundle -> first word written; no second write; err=1, err_code=2, in_ready=0; a following start clears err and restarts at address BASE_ADDR.
- beq with imm=3 -> err_code=3; opcode 1111111 -> err_code=1; neither writes memory.
- DEPTH=4 override, five bundles without in_last -> 4 writes, 5th sets err_code=4, word_count stays 4.
- rst_n=0 for one cycle mid-stream, on the cycle after an accepted bundle -> mem_we=0 that cycle, all outputs 0, state IDLE; in_valid ignored until start.
